// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared definitions for the run/step/halt controller.
//   STATE_W     : width of the controller state encoding
//   run_state_e : controller states IDLE=0, RUN=1, STEP=2, HALT=3
package run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } run_state_e;

endpackage

// File: rtl/run_ctrl_btn_pulse.sv
// btn_pulse: synchronizes a raw asynchronous button, debounces it and emits
// a single-cycle pulse on each accepted press.
//   clk, rst : clock, synchronous active-high reset
//   btn_i    : raw button level (asynchronous)
//   pulse_o  : one-cycle pulse, visible 2+DBNC_CYCLES cycles after the raw
//              edge is first sampled; holding the button gives one pulse
module btn_pulse
  import run_ctrl_pkg::*;
#(
  parameter int DBNC_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DBNC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronized level differs from the
  // accepted level; any return to the accepted level restarts it, so a
  // glitch shorter than DBNC_CYCLES never gets through.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        pulse_q  <= sync2_q;  // only the press direction produces a pulse
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run / single-step / halt controller for a CPU program counter.
//   clk, rst       : clock, synchronous active-high reset
//   run_btn, step_btn, halt_btn : raw asynchronous buttons
//   cpu_halt       : halt request from the decoded instruction
//   pc, bp_addr    : current program counter and breakpoint address
//   bp_valid       : breakpoint armed
//   pc_en          : PC advances this cycle (combinational)
//   state          : current controller state (run_state_e encoding)
//   halted         : high in IDLE or HALT
//   bp_hit         : sticky breakpoint-stop flag
//   cycle_cnt      : number of cycles with pc_en=1 (wraps)
// Build option: define RUN_CTRL_BP_EN to include the breakpoint logic;
// without it bp_addr/bp_valid are ignored and bp_hit is 0.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DBNC_CYCLES = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_btn,
  input  logic               step_btn,
  input  logic               halt_btn,
  input  logic               cpu_halt,
  input  logic [31:0]        pc,
  input  logic [31:0]        bp_addr,
  input  logic               bp_valid,
  output logic               pc_en,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   cycle_cnt
);

  logic       run_p;
  logic       step_p;
  logic       halt_p;
  logic       bp_match;
  logic       stop;
  logic       accept;
  run_state_e state_q;
  run_state_e state_d;
  logic [CNT_W-1:0] cnt_q;

  btn_pulse #(.DBNC_CYCLES(DBNC_CYCLES)) u_run_btn (
    .clk(clk), .rst(rst), .btn_i(run_btn), .pulse_o(run_p)
  );
  btn_pulse #(.DBNC_CYCLES(DBNC_CYCLES)) u_step_btn (
    .clk(clk), .rst(rst), .btn_i(step_btn), .pulse_o(step_p)
  );
  btn_pulse #(.DBNC_CYCLES(DBNC_CYCLES)) u_halt_btn (
    .clk(clk), .rst(rst), .btn_i(halt_btn), .pulse_o(halt_p)
  );

  // A run or step pulse is only acted on while stopped, and a simultaneous
  // halt pulse cancels it.
  assign accept = ((state_q == IDLE) || (state_q == HALT)) && !halt_p &&
                  (run_p || step_p);

`ifdef RUN_CTRL_BP_EN
  logic first_q;
  logic bp_hit_q;

  // first_q marks the first RUN cycle so a resume from the breakpoint
  // address executes that instruction instead of stopping again.
  assign bp_match = (state_q == RUN) && !first_q && bp_valid && (pc == bp_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      first_q <= (state_d == RUN) && (state_q != RUN);
      if (bp_match) begin
        bp_hit_q <= 1'b1;
      end else if (accept) begin
        bp_hit_q <= 1'b0;
      end
    end
  end

  assign bp_hit = bp_hit_q;
`else
  wire unused_bp = ^{pc, bp_addr, bp_valid};

  assign bp_match = 1'b0;
  assign bp_hit   = 1'b0;
`endif

  assign stop = halt_p || cpu_halt || bp_match;

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (halt_p) begin
          state_d = state_q;
        end else if (step_p) begin
          state_d = STEP;
        end else if (run_p) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HALT;
        end else begin
          pc_en = 1'b1;
        end
      end
      STEP: begin
        // cpu_halt is deliberately ignored: the step always executes.
        pc_en   = 1'b1;
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == IDLE) || (state_q == HALT);
  assign cycle_cnt = cnt_q;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter DBNC_CYCLES, default 16, cycles a synchronized button must stay stable before it is accepted.
REQ-002 SHALL have parameter CNT_W, default 32, width of the executed-cycle counter.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port run_btn  input  1  raw asynchronous "run" button.
REQ-006 SHALL have port step_btn  input  1  raw asynchronous "single-step" button.
REQ-007 SHALL have port halt_btn  input  1  raw asynchronous "halt" button.
REQ-008 SHALL have port cpu_halt  input  1  synchronous halt request from the decoded instruction.
REQ-009 SHALL have port pc  input  32  current program counter value.
REQ-010 SHALL have port bp_addr  input  32  breakpoint address.
REQ-011 SHALL have port bp_valid  input  1  breakpoint armed.
REQ-012 SHALL have port pc_en  output  1  PC update enable; 1 = PC loads next address this cycle, 0 = PC holds.
REQ-013 SHALL have port state  output  2  current FSM state encoding.
REQ-014 SHALL have port halted  output  1  high in IDLE or HALT.
REQ-015 SHALL have port bp_hit  output  1  sticky breakpoint-stop flag.
REQ-016 SHALL have port cycle_cnt  output  CNT_W  count of cycles with pc_en=1.

Function
REQ-017 Each button SHALL pass a 2-FF synchronizer and a stability counter; a debounced rising edge SHALL produce a one-cycle pulse 2+DBNC_CYCLES cycles after the raw edge; holding the button SHALL not repeat the pulse.
REQ-018 The FSM SHALL have states IDLE=0, RUN=1, STEP=2, HALT=3.
REQ-019 Pulse priority in the same cycle SHALL be halt > step > run.
REQ-020 IDLE/HALT: step pulse -> STEP; run pulse -> RUN; halt pulse or none -> stay.
REQ-021 STEP: pc_en=1 for exactly that one cycle, then -> HALT unconditionally.
REQ-022 RUN: pc_en=1 unless a stop condition holds; stop conditions = halt pulse, cpu_halt, breakpoint match; on a stop, pc_en=0 in that same cycle and next state = HALT.
REQ-023 Breakpoint match SHALL be bp_valid && pc==bp_addr, evaluated only in RUN, and suppressed in the first RUN cycle after entering from HALT/IDLE so execution can resume from a breakpoint address.
REQ-024 bp_hit SHALL set on a breakpoint stop and clear on the next accepted run or step pulse.
REQ-025 pc_en SHALL be combinational from state and stop conditions (zero latency), 0 in IDLE and HALT.
REQ-026 cycle_cnt SHALL increment by 1 each cycle pc_en=1 and wrap from 2^CNT_W-1 to 0.
REQ-027 cpu_halt asserted in STEP SHALL not suppress the step cycle; the FSM still goes to HALT.

Reset
REQ-028 rst SHALL force state=IDLE, pc_en=0, halted=1, bp_hit=0, cycle_cnt=0, and clear synchronizers and debounce counters; a reset mid-RUN or mid-STEP SHALL abort with pc_en=0 in the following cycle.

Configuration
REQ-029 Macro RUN_CTRL_BP_EN defined: breakpoint logic per REQ-023/024 is present.
REQ-030 RUN_CTRL_BP_EN undefined: bp_addr and bp_valid are ignored, and bp_hit is tied to 0.

Structure
REQ-031 A shared package SHALL hold the state enum typedef (IDLE/RUN/STEP/HALT) and the 2-bit state width constant.
REQ-032 Debounce and edge logic SHALL be one sub-module, btn_pulse, instantiated three times.

Verification (DBNC_CYCLES=4, CNT_W=8)
REQ-033 rst 3 cycles, then a step_btn pulse -> pc_en high exactly 1 cycle 6 cycles after the press; state returns to 3; cycle_cnt=1.
REQ-034 run_btn press, then cpu_halt high at cycle 20 of RUN -> pc_en=0 that cycle; state=3; cycle_cnt=19.
REQ-035 bp_addr=0x10, bp_valid=1, pc stepping 0,4,8..., run -> stop with pc_en=0 when pc=0x10; bp_hit=1; then run again -> pc advances past 0x10 and bp_hit clears.
REQ-036 run_btn and halt_btn pressed together from HALT -> state stays 3; pc_en stays 0.
REQ-037 run held for 260 enabled cycles -> cycle_cnt wraps to 4.
REQ-038 Button bouncing (3-cycle glitches) during RUN -> no spurious pulse; rst asserted mid-RUN -> pc_en=0 and state=0 next cycle.
